// File: rtl/kgp_branch_pkg.sv
// rtl/kgp_branch_pkg.sv - branch opcodes, FSM states and PC constants for the next-PC stage
package kgp_branch_pkg;

  localparam logic [3:0] BR_NONE = 4'd0;
  localparam logic [3:0] BR_B    = 4'd1;
  localparam logic [3:0] BR_BR   = 4'd2;
  localparam logic [3:0] BR_BLTZ = 4'd3;
  localparam logic [3:0] BR_BZ   = 4'd4;
  localparam logic [3:0] BR_BNZ  = 4'd5;
  localparam logic [3:0] BR_BL   = 4'd6;
  localparam logic [3:0] BR_BCY  = 4'd7;
  localparam logic [3:0] BR_BNCY = 4'd8;

  typedef enum logic [1:0] {
    ST_BOOT   = 2'd0,
    ST_RUN    = 2'd1,
    ST_HALTED = 2'd2
  } state_t;

  localparam logic [31:0] PC_INC = 32'd4;

endpackage

// File: rtl/branch_cond_eval.sv
// rtl/branch_cond_eval.sv - combinational branch-taken decision
module branch_cond_eval
  import kgp_branch_pkg::*;
(
  input  logic [3:0]  br_op,
  input  logic [31:0] rs_val,
  input  logic        carry_flag,
  output logic        cond
);

  always_comb begin
    cond = 1'b0;
    case (br_op)
      BR_B, BR_BL, BR_BR: cond = 1'b1;
      BR_BLTZ:            cond = rs_val[31];
      BR_BZ:              cond = (rs_val == 32'd0);
      BR_BNZ:             cond = (rs_val != 32'd0);
      BR_BCY:             cond = carry_flag;
      BR_BNCY:            cond = ~carry_flag;
      default:            cond = 1'b0;
    endcase
  end

endmodule

// File: rtl/next_pc_unit.sv
// rtl/next_pc_unit.sv - PC sequencing, branch resolution, carry flag and retire counter
module next_pc_unit
  import kgp_branch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TARGET_W = 26
)(
  input  logic                clk,
  input  logic                rst,
  input  logic                adv,
  input  logic [3:0]          br_op,
  input  logic [TARGET_W-1:0] br_target,
  input  logic [31:0]         rs_val,
  input  logic                alu_carry,
  input  logic                alu_carry_we,
  input  logic                halt,
  output logic [31:0]         pc,
  output logic                pc_valid,
  output logic                taken,
  output logic                link_we,
  output logic [31:0]         link_data,
  output logic                carry_flag,
  output logic [31:0]         retired
);

  state_t      state, state_next;
  logic        cond;
  logic        retire;
  logic        do_branch;
  logic        do_link;
  logic [31:0] pc_seq;
  logic [31:0] target_ext;
  logic [31:0] pc_next;

  branch_cond_eval u_cond (
    .br_op      (br_op),
    .rs_val     (rs_val),
    .carry_flag (carry_flag),
    .cond       (cond)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= ST_BOOT;
    else      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      ST_BOOT:   state_next = ST_RUN;
      ST_RUN:    if (adv && halt) state_next = ST_HALTED;
      ST_HALTED: state_next = ST_HALTED;
      default:   state_next = ST_BOOT;
    endcase
  end

  // halt suppresses every branch effect of the retiring instruction
  always_comb begin
    retire    = adv && (state == ST_RUN);
    do_branch = retire && !halt && cond;
    do_link   = retire && !halt && (br_op == BR_BL);
  end

  assign pc_seq     = pc + PC_INC;
  assign target_ext = {{(32-TARGET_W){1'b0}}, br_target};

  always_comb begin
    pc_next = pc;
    if (retire && !halt) begin
      if (!cond)                 pc_next = pc_seq;
      else if (br_op == BR_BR)   pc_next = rs_val;
      else                       pc_next = target_ext;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc         <= RESET_PC;
      pc_valid   <= 1'b0;
      taken      <= 1'b0;
      link_we    <= 1'b0;
      link_data  <= 32'd0;
      carry_flag <= 1'b0;
      retired    <= 32'd0;
    end else begin
      pc       <= pc_next;
      pc_valid <= (state_next == ST_RUN);
      taken    <= do_branch;
      link_we  <= do_link;
      if (do_link)
        link_data <= pc_seq;
      // flag update lands after the condition already sampled the old value
      if (retire && alu_carry_we)
        carry_flag <= alu_carry;
      if (retire && (retired != 32'hFFFF_FFFF))
        retired <= retired + 32'd1;
    end
  end

endmodule

// File: tb/tb_next_pc_unit.sv
// tb/tb_next_pc_unit.sv - scoreboard bench for next_pc_unit with directed vectors
module tb_next_pc_unit;
  import kgp_branch_pkg::*;

  logic        clk;
  logic        rst;
  logic        adv;
  logic [3:0]  br_op;
  logic [25:0] br_target;
  logic [31:0] rs_val;
  logic        alu_carry;
  logic        alu_carry_we;
  logic        halt;
  logic [31:0] pc;
  logic        pc_valid;
  logic        taken;
  logic        link_we;
  logic [31:0] link_data;
  logic        carry_flag;
  logic [31:0] retired;

  typedef struct {
    logic [31:0] pc;
    logic        valid;
    logic        taken;
    logic        lwe;
    logic [31:0] ldata;
    logic        cf;
    logic [31:0] ret;
  } exp_t;

  exp_t q[$];
  int   checks = 0;
  int   errors = 0;

  next_pc_unit #(.RESET_PC(32'h0), .TARGET_W(26)) dut (
    .clk          (clk),
    .rst          (rst),
    .adv          (adv),
    .br_op        (br_op),
    .br_target    (br_target),
    .rs_val       (rs_val),
    .alu_carry    (alu_carry),
    .alu_carry_we (alu_carry_we),
    .halt         (halt),
    .pc           (pc),
    .pc_valid     (pc_valid),
    .taken        (taken),
    .link_we      (link_we),
    .link_data    (link_data),
    .carry_flag   (carry_flag),
    .retired      (retired)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic a, input logic [3:0] op, input logic [25:0] tgt,
                       input logic [31:0] rs, input logic ac, input logic acwe, input logic hl);
    adv = a; br_op = op; br_target = tgt; rs_val = rs;
    alu_carry = ac; alu_carry_we = acwe; halt = hl;
  endtask

  task automatic expect_out(input logic [31:0] epc, input logic ev, input logic et, input logic elw,
                            input logic [31:0] eld, input logic ecf, input logic [31:0] eret);
    q.push_back('{epc, ev, et, elw, eld, ecf, eret});
  endtask

  task automatic step(input logic a, input logic [3:0] op, input logic [25:0] tgt,
                      input logic [31:0] rs, input logic ac, input logic acwe, input logic hl,
                      input logic [31:0] epc, input logic ev, input logic et, input logic elw,
                      input logic [31:0] eld, input logic ecf, input logic [31:0] eret);
    @(negedge clk);
    drive(a, op, tgt, rs, ac, acwe, hl);
    expect_out(epc, ev, et, elw, eld, ecf, eret);
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, ".pc"},        pc, 32'h0);
    chk({tag, ".pc_valid"},  {31'd0, pc_valid}, 32'd0);
    chk({tag, ".taken"},     {31'd0, taken}, 32'd0);
    chk({tag, ".link_we"},   {31'd0, link_we}, 32'd0);
    chk({tag, ".link_data"}, link_data, 32'h0);
    chk({tag, ".carry"},     {31'd0, carry_flag}, 32'd0);
    chk({tag, ".retired"},   retired, 32'h0);
  endtask

  // monitor: registered outputs are compared 1 time unit after each rising edge
  always begin
    exp_t e;
    @(posedge clk);
    #1;
    if (q.size() > 0) begin
      e = q.pop_front();
      chk("pc",        pc, e.pc);
      chk("pc_valid",  {31'd0, pc_valid}, {31'd0, e.valid});
      chk("taken",     {31'd0, taken}, {31'd0, e.taken});
      chk("link_we",   {31'd0, link_we}, {31'd0, e.lwe});
      chk("link_data", link_data, e.ldata);
      chk("carry",     {31'd0, carry_flag}, {31'd0, e.cf});
      chk("retired",   retired, e.ret);
    end
  end

  initial begin
    int waited;
    rst = 1'b1;
    drive(1'b0, BR_NONE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #2 rst = 1'b0;
    #1 chk_reset_state("reset");
    @(negedge clk);
    @(negedge clk);

    // release: BOOT cycle, adv ignored
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, BR_B, 26'h3F0, 32'h0, 1'b1, 1'b1, 1'b0);
    #1 chk("boot.pc_valid", {31'd0, pc_valid}, 32'd0);
    expect_out(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0);

    //   adv op       tgt        rs             ac    acwe  halt   pc             v     t     lwe   ldata          cf    ret
    step(1'b1, BR_NONE, 26'h0,   32'h0,         1'b0, 1'b0, 1'b0,  32'h4,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd1);
    step(1'b1, BR_NONE, 26'h0,   32'h0,         1'b0, 1'b0, 1'b0,  32'h8,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd2);
    step(1'b1, BR_NONE, 26'h0,   32'h0,         1'b0, 1'b0, 1'b0,  32'hC,         1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd3);
    step(1'b1, BR_BLTZ, 26'h100, 32'h8000_0001, 1'b0, 1'b0, 1'b0,  32'h100,       1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'd4);
    step(1'b1, BR_BZ,   26'h300, 32'h5,         1'b0, 1'b0, 1'b0,  32'h104,       1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd5);
    step(1'b1, BR_NONE, 26'h0,   32'h0,         1'b1, 1'b1, 1'b0,  32'h108,       1'b1, 1'b0, 1'b0, 32'h0,         1'b1, 32'd6);
    step(1'b1, BR_BCY,  26'h40,  32'h0,         1'b0, 1'b0, 1'b0,  32'h40,        1'b1, 1'b1, 1'b0, 32'h0,         1'b1, 32'd7);
    // BNCY sees old carry=1 (not taken) while the flag clears
    step(1'b1, BR_BNCY, 26'h500, 32'h0,         1'b0, 1'b1, 1'b0,  32'h44,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd8);
    step(1'b1, BR_BNCY, 26'h60,  32'h0,         1'b1, 1'b0, 1'b0,  32'h60,        1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'd9);
    step(1'b1, BR_BR,   26'h0,   32'h200,       1'b0, 1'b0, 1'b0,  32'h200,       1'b1, 1'b1, 1'b0, 32'h0,         1'b0, 32'd10);
    step(1'b1, BR_BL,   26'h80,  32'h0,         1'b0, 1'b0, 1'b0,  32'h80,        1'b1, 1'b1, 1'b1, 32'h204,       1'b0, 32'd11);
    step(1'b1, BR_BR,   26'h0,   32'h204,       1'b0, 1'b0, 1'b0,  32'h204,       1'b1, 1'b1, 1'b0, 32'h204,       1'b0, 32'd12);
    step(1'b0, BR_B,    26'h9,   32'h0,         1'b1, 1'b1, 1'b0,  32'h204,       1'b1, 1'b0, 1'b0, 32'h204,       1'b0, 32'd12);
    step(1'b1, BR_BNZ,  26'h700, 32'h0,         1'b0, 1'b0, 1'b0,  32'h208,       1'b1, 1'b0, 1'b0, 32'h204,       1'b0, 32'd13);
    step(1'b1, BR_BR,   26'h0,   32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0,  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h204,       1'b0, 32'd14);
    step(1'b1, BR_NONE, 26'h0,   32'h0,         1'b0, 1'b0, 1'b0,  32'h0,         1'b1, 1'b0, 1'b0, 32'h204,       1'b0, 32'd15);
    step(1'b1, BR_BR,   26'h0,   32'hFFFF_FFFC, 1'b0, 1'b0, 1'b0,  32'hFFFF_FFFC, 1'b1, 1'b1, 1'b0, 32'h204,       1'b0, 32'd16);
    step(1'b1, BR_BL,   26'h10,  32'h0,         1'b0, 1'b0, 1'b0,  32'h10,        1'b1, 1'b1, 1'b1, 32'h0,         1'b0, 32'd17);
    step(1'b1, 4'hF,    26'h900, 32'h0,         1'b0, 1'b0, 1'b0,  32'h14,        1'b1, 1'b0, 1'b0, 32'h0,         1'b0, 32'd18);
    step(1'b1, BR_B,    26'h30,  32'h0,         1'b1, 1'b1, 1'b1,  32'h14,        1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'd19);
    step(1'b1, BR_B,    26'h50,  32'h0,         1'b0, 1'b1, 1'b0,  32'h14,        1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'd19);
    step(1'b0, BR_NONE, 26'h0,   32'h0,         1'b0, 1'b0, 1'b0,  32'h14,        1'b0, 1'b0, 1'b0, 32'h0,         1'b1, 32'd19);

    // asynchronous reset in the middle of a cycle
    @(posedge clk);
    #3 rst = 1'b0;
    #1 chk_reset_state("midreset");
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    drive(1'b1, BR_NONE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0);
    #1 chk("reboot.pc_valid", {31'd0, pc_valid}, 32'd0);
    expect_out(32'h0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd0);
    step(1'b1, BR_NONE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0,  32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd1);
    step(1'b0, BR_NONE, 26'h0, 32'h0, 1'b0, 1'b0, 1'b0,  32'h4, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'd1);

    waited = 0;
    while (q.size() > 0 && waited < 100) begin
      @(posedge clk);
      waited++;
    end
    #3;
    if (q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
